// File: rtl/accum_rmw_ctrl.sv
// Read-modify-write sequencer for one accumulator column SRAM (1R/1W, 1-cycle read latency).
// Write-data forwarding gives 1 op/cycle to any address mix; also sequences a whole-column clear.
module accum_rmw_ctrl #(
   parameter int unsigned ACCUM_ROW  = 256,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  clear_start,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic                  sram_rd_en,
   output logic [ADDR_WIDTH-1:0] sram_rd_addr,
   input  logic [DATA_WIDTH-1:0] sram_rd_data,
   output logic                  sram_wr_en,
   output logic [ADDR_WIDTH-1:0] sram_wr_addr,
   output logic [DATA_WIDTH-1:0] sram_wr_data
);

   localparam logic [1:0] OpAcc     = 2'd0;
   localparam logic [1:0] OpLoad    = 2'd1;
   localparam logic [1:0] OpRead    = 2'd2;
   localparam logic [1:0] OpReadClr = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] LastRow = ADDR_WIDTH'(ACCUM_ROW - 1);

   typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  clear_done_q, clear_done_d;

   logic                  p1_valid_q, p1_valid_d;
   logic [1:0]            p1_op_q, p1_op_d;
   logic [ADDR_WIDTH-1:0] p1_addr_q, p1_addr_d;
   logic [DATA_WIDTH-1:0] p1_data_q, p1_data_d;

   logic                  fwd_valid_q, fwd_valid_d;
   logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
   logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

   logic                  out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic                  accept;
   logic                  clear_wr;
   logic                  s1_wr;
   logic [DATA_WIDTH-1:0] s1_wr_data;
   logic [DATA_WIDTH-1:0] old_data;

   // Control FSM; in_ready is forced low while rst is held.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clear_done_d = 1'b0;
      in_ready     = 1'b0;
      clear_busy   = 1'b0;
      clear_wr     = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = ~clear_start;
            if (clear_start) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            clear_busy = 1'b1;
            if (!p1_valid_q) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
         StClear: begin
            clear_busy = 1'b1;
            clear_wr   = 1'b1;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LastRow) begin
               state_d      = StIdle;
               clear_done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      in_ready = in_ready & ~rst;
   end

   assign accept       = in_valid & in_ready;
   assign sram_rd_en   = accept;
   assign sram_rd_addr = in_addr;

   always_comb begin
      p1_valid_d = accept;
      p1_op_d    = p1_op_q;
      p1_addr_d  = p1_addr_q;
      p1_data_d  = p1_data_q;
      if (accept) begin
         p1_op_d   = in_op;
         p1_addr_d = in_addr;
         p1_data_d = in_data;
      end
   end

   // Stage S1: forwarded value covers the SRAM's read-during-write returning stale data.
   always_comb begin
      old_data = (fwd_valid_q && (fwd_addr_q == p1_addr_q)) ? fwd_data_q : sram_rd_data;
      s1_wr    = p1_valid_q && (p1_op_q != OpRead);
      unique case (p1_op_q)
         OpAcc:     s1_wr_data = old_data + p1_data_q;
         OpLoad:    s1_wr_data = p1_data_q;
         OpReadClr: s1_wr_data = '0;
         default:   s1_wr_data = '0;
      endcase
   end

   assign sram_wr_en   = (s1_wr | clear_wr) & ~rst;
   assign sram_wr_addr = clear_wr ? cnt_q : p1_addr_q;
   assign sram_wr_data = clear_wr ? '0 : s1_wr_data;

   always_comb begin
      fwd_valid_d = fwd_valid_q;
      fwd_addr_d  = fwd_addr_q;
      fwd_data_d  = fwd_data_q;
      if (sram_wr_en) begin
         fwd_valid_d = 1'b1;
         fwd_addr_d  = sram_wr_addr;
         fwd_data_d  = sram_wr_data;
      end
   end

   always_comb begin
      out_valid_d = p1_valid_q && p1_op_q[1];
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      if (out_valid_d) begin
         out_addr_d = p1_addr_q;
         out_data_d = old_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         clear_done_q <= 1'b0;
         p1_valid_q   <= 1'b0;
         p1_op_q      <= '0;
         p1_addr_q    <= '0;
         p1_data_q    <= '0;
         fwd_valid_q  <= 1'b0;
         fwd_addr_q   <= '0;
         fwd_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clear_done_q <= clear_done_d;
         p1_valid_q   <= p1_valid_d;
         p1_op_q      <= p1_op_d;
         p1_addr_q    <= p1_addr_d;
         p1_data_q    <= p1_data_d;
         fwd_valid_q  <= fwd_valid_d;
         fwd_addr_q   <= fwd_addr_d;
         fwd_data_q   <= fwd_data_d;
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         out_data_q   <= out_data_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_addr   = out_addr_q;
   assign out_data   = out_data_q;
   assign clear_done = clear_done_q;

endmodule

// File: tb/tb_accum_rmw_ctrl.sv
// Bench for accum_rmw_ctrl: behavioural SRAM, reference memory model and a read-result
// scoreboard, plus directed clear and reset-during-clear sequences.
module tb_accum_rmw_ctrl;

   localparam int unsigned Rows = 256;
   localparam int unsigned Dw   = 32;
   localparam int unsigned Aw   = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_op;
   logic [Aw-1:0] in_addr;
   logic [Dw-1:0] in_data;
   logic          out_valid;
   logic [Aw-1:0] out_addr;
   logic [Dw-1:0] out_data;
   logic          clear_start;
   logic          clear_busy;
   logic          clear_done;
   logic          sram_rd_en;
   logic [Aw-1:0] sram_rd_addr;
   logic [Dw-1:0] sram_rd_data;
   logic          sram_wr_en;
   logic [Aw-1:0] sram_wr_addr;
   logic [Dw-1:0] sram_wr_data;

   accum_rmw_ctrl #(
      .ACCUM_ROW  (Rows),
      .DATA_WIDTH (Dw)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_addr     (out_addr),
      .out_data     (out_data),
      .clear_start  (clear_start),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .sram_rd_en   (sram_rd_en),
      .sram_rd_addr (sram_rd_addr),
      .sram_rd_data (sram_rd_data),
      .sram_wr_en   (sram_wr_en),
      .sram_wr_addr (sram_wr_addr),
      .sram_wr_data (sram_wr_data)
   );

   always #5 clk = ~clk;

   // Registered-read SRAM; same-cycle read of a row being written returns the old word.
   logic [Dw-1:0] mem [Rows];
   always @(posedge clk) begin
      if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
      if (sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
   end

   typedef struct {
      logic [Aw-1:0] addr;
      logic [Dw-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [Dw-1:0] model_mem [Rows];
   int            cyc = 0;
   int            n_checks = 0;
   int            n_pass = 0;
   int            done_cnt = 0;
   bit            chk_ready = 1'b0;
   logic [Dw-1:0] last_data = '0;
   logic [Aw-1:0] last_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Monitor: compare results first, then fold this cycle's accepted op into the model.
   always @(negedge clk) begin
      if (!rst) begin
         if (clear_done) done_cnt++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("out_addr", 64'(out_addr), 64'(mon_e.addr));
               check_eq("out_data", 64'(out_data), 64'(mon_e.data));
               check_eq("out_latency", 64'(cyc - mon_e.cyc), 64'd2);
               last_data = out_data;
               last_addr = out_addr;
            end
         end
         if (chk_ready && in_valid) check_eq("ready_in_idle", 64'(in_ready), 64'd1);
         if (in_valid && in_ready) begin
            case (in_op)
               2'd0: model_mem[in_addr] = model_mem[in_addr] + in_data;
               2'd1: model_mem[in_addr] = in_data;
               2'd2: exp_q.push_back('{addr: in_addr, data: model_mem[in_addr], cyc: cyc});
               default: begin
                  exp_q.push_back('{addr: in_addr, data: model_mem[in_addr], cyc: cyc});
                  model_mem[in_addr] = '0;
               end
            endcase
         end
      end
   end

   task automatic do_op(input logic [1:0] op, input int addr, input logic [Dw-1:0] data);
      in_valid = 1'b1;
      in_op    = op;
      in_addr  = addr[Aw-1:0];
      in_data  = data;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int  accepts;
      int  busy_n, nwr, wr_bad, rdy_bad, first_wr, done_k;
      bit  found;
      for (int i = 0; i < Rows; i++) begin
         mem[i]       = '0;
         model_mem[i] = '0;
      end
      rst         = 1'b1;
      in_valid    = 1'b1;
      in_op       = 2'd2;
      in_addr     = '0;
      in_data     = '0;
      clear_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      check_eq("rst_rd_en", 64'(sram_rd_en), 64'd0);
      check_eq("rst_wr_en", 64'(sram_wr_en), 64'd0);
      check_eq("rst_out", {31'd0, out_valid, out_addr, out_data}, 64'd0);
      check_eq("rst_clear", {62'd0, clear_busy, clear_done}, 64'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Back-to-back hazards on one row.
      do_op(2'd1, 5, 32'd10);
      do_op(2'd0, 5, 32'd3);
      do_op(2'd0, 5, 32'd4);
      do_op(2'd2, 5, 32'd0);
      idle(3);
      check_eq("acc_chain_data", 64'(last_data), 64'd17);
      check_eq("acc_chain_addr", 64'(last_addr), 64'd5);

      do_op(2'd1, 7, 32'hFFFF_FFFF);
      do_op(2'd0, 7, 32'd2);
      do_op(2'd2, 7, 32'd0);
      idle(3);
      check_eq("acc_wrap", 64'(last_data), 64'd1);

      do_op(2'd1, 3, 32'd42);
      idle(1);
      do_op(2'd3, 3, 32'd0);
      idle(3);
      check_eq("read_clr_old", 64'(last_data), 64'd42);
      do_op(2'd3, 3, 32'd0);
      do_op(2'd2, 3, 32'd0);
      idle(3);
      check_eq("read_after_clr", 64'(last_data), 64'd0);
      idle(1);
      do_op(2'd0, 3, 32'd9);
      do_op(2'd2, 3, 32'd0);
      idle(3);
      check_eq("acc_after_clr", 64'(last_data), 64'd9);

      // Column clear with an ACC still in S1 when clear_start arrives.
      in_valid = 1'b1;
      in_op    = 2'd0;
      in_addr  = 8'd1;
      in_data  = 32'd5;
      @(posedge clk);
      #1;
      in_op       = 2'd2;
      in_addr     = 8'd0;
      clear_start = 1'b1;
      for (int i = 0; i < Rows; i++) model_mem[i] = '0;
      @(negedge clk);
      check_eq("ready_on_clear_start", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      busy_n = 0; nwr = 0; wr_bad = 0; rdy_bad = 0; first_wr = -1; done_k = -1;
      for (int k = 1; k <= 262; k++) begin
         @(negedge clk);
         if (clear_busy) begin
            busy_n++;
            if (in_ready) rdy_bad++;
            if (sram_wr_en) begin
               if (first_wr < 0) first_wr = k;
               if (32'(sram_wr_addr) != nwr || sram_wr_data != '0) wr_bad++;
               nwr++;
            end
         end
         if (clear_done) done_k = k;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("clear_busy_cycles", 64'(busy_n), 64'd257);
      check_eq("clear_writes", 64'(nwr), 64'(Rows));
      check_eq("clear_write_bad", 64'(wr_bad), 64'd0);
      check_eq("clear_ready_bad", 64'(rdy_bad), 64'd0);
      check_eq("clear_first_write", 64'(first_wr), 64'd2);
      check_eq("clear_done_cycle", 64'(done_k), 64'(Rows + 2));
      check_eq("clear_done_count", 64'(done_cnt), 64'd1);
      do_op(2'd2, 0, 32'd0);
      do_op(2'd2, 1, 32'd0);
      do_op(2'd2, 255, 32'd0);
      idle(3);
      check_eq("after_clear_row255", {24'd0, last_addr, last_data}, 64'hFF_0000_0000);

      // Random stream over four rows.
      chk_ready = 1'b1;
      accepts   = 0;
      for (int c = 0; c < 6000 && accepts < 2000; c++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_op    = 2'($urandom_range(0, 3));
         in_addr  = 8'($urandom_range(0, 3));
         in_data  = $urandom;
         if (in_valid) accepts++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      chk_ready = 1'b0;
      idle(4);
      check_eq("random_accepts", 64'(accepts), 64'd2000);

      // Reset while the clear is at row 100.
      do_op(2'd1, 99, 32'h99);
      do_op(2'd1, 100, 32'h100);
      do_op(2'd1, 255, 32'h255);
      idle(2);
      clear_start = 1'b1;
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clk);
         if (sram_wr_en && clear_busy && sram_wr_addr == 8'd99) found = 1'b1;
      end
      check_eq("saw_clear_row99", 64'(found), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_wr_en", 64'(sram_wr_en), 64'd0);
      check_eq("rst_mid_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 100; i++) model_mem[i] = '0;
      check_eq("post_rst_busy", 64'(clear_busy), 64'd0);
      check_eq("post_rst_outs", {30'd0, out_valid, clear_done, sram_wr_en, sram_rd_en}, 64'd0);
      idle(300);
      do_op(2'd2, 99, 32'd0);
      do_op(2'd2, 255, 32'd0);
      do_op(2'd2, 50, 32'd0);
      do_op(2'd2, 100, 32'd0);
      idle(3);
      check_eq("row100_kept", 64'(last_data), 64'h100);
      check_eq("no_done_after_rst", 64'(done_cnt), 64'd1);
      check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
